// File: rtl/teng_phy_pkg.sv
// Shared 10G PHY constants: block and word geometry and the 64b/66b sync headers.
package teng_phy_pkg;
   localparam int BLOCK_W = 66;
   localparam int WORD_W  = 32;
   localparam int BUF_W   = 128;
   localparam int LVL_W   = 7;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;
endpackage

// File: rtl/tx_gearbox_66to32_if.sv
// Block-in / word-out bundle between scrambler, gearbox and transceiver TX port.
interface tx_gearbox_66to32_if;
   import teng_phy_pkg::*;

   logic [BLOCK_W-1:0] data_i;
   logic               data_vld_i;
   logic               data_rdy_o;
   logic [WORD_W-1:0]  data_o;
   logic               data_vld_o;
   logic               underrun_o;

   modport master (
      output data_i, data_vld_i,
      input  data_rdy_o, data_o, data_vld_o, underrun_o
   );

   modport slave (
      input  data_i, data_vld_i,
      output data_rdy_o, data_o, data_vld_o, underrun_o
   );
endinterface

// File: rtl/tx_gearbox_66to32.sv
// 66-to-32 TX gearbox: LSB-aligned bit buffer, one 32-bit word out per cycle while
// at least 32 bits are held, 66-bit blocks pulled in whenever the level allows.
module tx_gearbox_66to32
   import teng_phy_pkg::*;
#(
   parameter int RDY_THRESH = 64
) (
   input logic                clk_i,
   input logic                rst_i,
   tx_gearbox_66to32_if.slave bus
);

   logic [BUF_W-1:0]  r_buf;
   logic [LVL_W-1:0]  r_lvl;
   logic              r_started;
   logic              r_rdy;
   logic              r_vld;
   logic              r_underrun;
   logic [WORD_W-1:0] r_data;

   logic              w_emit;
   logic              w_acc;
   logic [LVL_W-1:0]  w_base;
   logic [LVL_W-1:0]  w_lvl_n;
   logic [BUF_W-1:0]  w_kept;
   logic [BUF_W-1:0]  w_new;
   logic [BUF_W-1:0]  w_buf_n;

   // New block lands just above whatever survives this cycle's emit.
   always_comb begin
      w_emit  = (r_lvl >= LVL_W'(WORD_W));
      w_acc   = bus.data_vld_i & r_rdy;
      w_base  = w_emit ? (r_lvl - LVL_W'(WORD_W)) : r_lvl;
      w_lvl_n = w_acc ? (w_base + LVL_W'(BLOCK_W)) : w_base;
      w_kept  = w_emit ? (r_buf >> WORD_W) : r_buf;
      w_new   = w_acc ? (BUF_W'(bus.data_i) << w_base) : '0;
      w_buf_n = w_kept | w_new;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_buf      <= '0;
         r_lvl      <= '0;
         r_started  <= 1'b0;
         r_rdy      <= 1'b0;
         r_vld      <= 1'b0;
         r_underrun <= 1'b0;
         r_data     <= '0;
      end else begin
         r_buf      <= w_buf_n;
         r_lvl      <= w_lvl_n;
         if (w_emit) begin
            r_data <= r_buf[WORD_W-1:0];
         end
         r_vld      <= w_emit;
         r_rdy      <= (int'(w_lvl_n) < RDY_THRESH);
         r_started  <= r_started | w_acc;
         // Gaps before the first block are just idle line, not an underrun.
         r_underrun <= r_underrun | (r_started & ~w_emit);
      end
   end

   assign bus.data_rdy_o = r_rdy;
   assign bus.data_o     = r_data;
   assign bus.data_vld_o = r_vld;
   assign bus.underrun_o = r_underrun;

endmodule

// File: tb/tb_tx_gearbox_66to32.sv
// Bench for tx_gearbox_66to32: accepted blocks feed a bit-level reassembly queue that a
// negedge monitor drains word by word, alongside a cycle model of valid/ready/underrun.
module tb_tx_gearbox_66to32;
   import teng_phy_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   tx_gearbox_66to32_if bus();

   tx_gearbox_66to32 #(.RDY_THRESH(64)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp  = 0;
   int n_fail = 0;

   bit          bitq[$];
   logic [31:0] dir_q[$];

   bit          prev_rst  = 1'b1;
   bit          m_emit    = 1'b0;
   bit          m_acc     = 1'b0;
   bit          m_started = 1'b0;
   bit          m_und     = 1'b0;
   logic [31:0] m_last    = '0;
   logic [31:0] m_word;
   int          acc_cnt    = 0;
   int          rdy_lo_cnt = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Monitor: state seen here is the DUT state after the preceding posedge.
   always @(negedge clk_i) begin
      if (prev_rst) begin
         chk("rst_vld_o", 64'(bus.data_vld_o), 64'(0));
         chk("rst_rdy_o", 64'(bus.data_rdy_o), 64'(0));
         chk("rst_underrun_o", 64'(bus.underrun_o), 64'(0));
         chk("rst_data_o", 64'(bus.data_o), 64'(0));
         bitq.delete();
         m_started = 1'b0;
         m_und     = 1'b0;
         m_last    = '0;
      end else begin
         m_und     = m_und | (m_started & ~m_emit);
         m_started = m_started | m_acc;
         chk("vld_o", 64'(bus.data_vld_o), 64'(m_emit));
         if (bus.data_vld_o) begin
            if (bitq.size() < 32) begin
               chk("bits_available", 64'(bitq.size()), 64'(32));
               bitq.delete();
            end else begin
               for (int i = 0; i < 32; i++) m_word[i] = bitq.pop_front();
               chk("word", 64'(bus.data_o), 64'(m_word));
               m_last = m_word;
            end
            if (dir_q.size() > 0) chk("directed_word", 64'(bus.data_o), 64'(dir_q.pop_front()));
         end else begin
            chk("data_hold", 64'(bus.data_o), 64'(m_last));
         end
         chk("rdy_o", 64'(bus.data_rdy_o), 64'(bitq.size() < 64));
         chk("underrun_o", 64'(bus.underrun_o), 64'(m_und));
         if (!bus.data_rdy_o) rdy_lo_cnt++;
      end
      chk("lvl_match", 64'(dut.r_lvl), 64'(bitq.size()));
      chk("lvl_max", 64'(dut.r_lvl <= 7'd97), 64'(1));
      chk("buf_clean", 64'((dut.r_buf >> dut.r_lvl) == '0), 64'(1));
      m_emit = (bitq.size() >= 32);
      m_acc  = bus.data_vld_i & bus.data_rdy_o & ~rst_i;
      if (m_acc) acc_cnt++;
      prev_rst = rst_i;
   end

   task automatic send(input logic [65:0] d);
      bit done;
      done = 1'b0;
      bus.data_i     = d;
      bus.data_vld_i = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk_i);
         done = bus.data_rdy_o && !rst_i;
         @(posedge clk_i);
         #1;
      end
      if (done) begin
         for (int i = 0; i < 66; i++) bitq.push_back(d[i]);
      end else begin
         chk("send_timeout", 64'(0), 64'(1));
      end
   endtask

   task automatic idle(input int n);
      bus.data_vld_i = 1'b0;
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      bus.data_vld_i = 1'b0;
      rst_i = 1'b1;
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
      rst_i = 1'b0;
   endtask

   task automatic probe(input string nm, input logic [63:0] act_sel, input logic [63:0] exp);
      chk(nm, act_sel, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   int a0, a1, r0;

   initial begin
      bus.data_i     = '0;
      bus.data_vld_i = 1'b0;
      do_reset(3);

      // Single block into an empty gearbox
      dir_q.push_back(32'h26AF37BD);
      dir_q.push_back(32'h048D159E);
      send({64'h0123456789ABCDEF, SYNC_DATA});
      idle(6);
      @(negedge clk_i);
      probe("t1_vld_dropped", 64'(bus.data_vld_o), 64'(0));
      probe("t1_underrun", 64'(bus.underrun_o), 64'(1));
      probe("t1_directed_done", 64'(dir_q.size()), 64'(0));
      @(posedge clk_i);
      #1;

      // Continuous valid with backpressure; steady-state block rate
      do_reset(2);
      r0 = rdy_lo_cnt;
      fork
         begin
            for (int i = 0; i < 200; i++)
               send({64'(i), (i % 2 == 0) ? SYNC_DATA : SYNC_CTRL});
            bus.data_vld_i = 1'b0;
         end
         begin
            repeat (40) @(posedge clk_i);
            a0 = acc_cnt;
            repeat (330) @(posedge clk_i);
            a1 = acc_cnt;
            chk("t2_blocks_per_330", 64'(a1 - a0), 64'(160));
         end
      join
      @(negedge clk_i);
      probe("t2_no_underrun", 64'(bus.underrun_o), 64'(0));
      probe("t2_backpressure_seen", 64'(rdy_lo_cnt > r0), 64'(1));
      @(posedge clk_i);
      #1;

      // Upstream gap of 3 cycles in steady state
      do_reset(2);
      for (int i = 0; i < 40; i++) send({64'h1000 + 64'(i), SYNC_DATA});
      idle(3);
      for (int i = 0; i < 40; i++) send({64'h2000 + 64'(i), SYNC_CTRL});
      idle(8);
      @(negedge clk_i);
      probe("t3_underrun_sticky", 64'(bus.underrun_o), 64'(1));
      probe("t3_drained", 64'(bitq.size() < 32), 64'(1));
      @(posedge clk_i);
      #1;

      // Reset while 34 bits are buffered
      do_reset(2);
      send({64'hAAAA5555CCCC3333, SYNC_DATA});
      idle(1);
      probe("t5_lvl_34", 64'(dut.r_lvl), 64'(34));
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      dir_q.delete();
      dir_q.push_back(32'hD950C842);
      dir_q.push_back(32'hFB72EA61);
      send({64'hFEDCBA9876543210, SYNC_CTRL});
      idle(5);
      @(negedge clk_i);
      probe("t5_directed_done", 64'(dir_q.size()), 64'(0));
      @(posedge clk_i);
      #1;

      // Random 50% valid
      do_reset(2);
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(1) == 1)
            send({$urandom(), $urandom(), 2'($urandom_range(1, 2))});
         else
            idle(1);
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
